// File: rtl/video_fmt_lock.sv
// Video format lock: measures active pixels/lines from hs/vs/de
// and locks once STABLE_FRAMES identical good frames are seen.
// Ports: clk, rst_n | hs, vs, de in | lock, h_active, v_active,
// fmt_change, timeout out.
module video_fmt_lock #(
  parameter int STABLE_FRAMES = 3,
  parameter int TIMEOUT_CYC   = 10000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic        vs,
  input  logic        de,
  output logic        lock,
  output logic [15:0] h_active,
  output logic [15:0] v_active,
  output logic        fmt_change,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    VERIFY,
    LOCKED
  } state_t;

  state_t      state, state_n;
  logic        hs_d, vs_d;
  logic        hs_rise, vs_rise;
  logic [15:0] px_cnt;
  logic [15:0] line_w, ln_cnt;
  logic        bad;
  logic [23:0] wd, wd_inc;
  logic [3:0]  stab, stab_n, stab_inc;
  logic [15:0] ref_h, ref_v, ref_h_n, ref_v_n;

  logic        line_cl, first;
  logic [15:0] lw_n, ln_n;
  logic        bad_n, good, match;
  logic        tmo, fmt_n, ld;

  assign hs_rise  = hs & ~hs_d;
  assign vs_rise  = vs & ~vs_d;
  assign wd_inc   = wd + 24'd1;
  assign stab_inc = stab + 4'd1;

  // Line/frame bookkeeping as seen at this cycle, including
  // a line that closes on the same cycle as the frame.
  always_comb begin
    line_cl = hs_rise && (px_cnt != 16'd0);
    first   = (ln_cnt == 16'd0);
    lw_n    = (line_cl && first) ? px_cnt : line_w;
    ln_n    = ln_cnt;
    if (line_cl && ln_cnt != 16'hFFFF)
      ln_n  = ln_cnt + 16'd1;
    bad_n   = bad |
              (line_cl && !first && px_cnt != line_w);
    good    = !bad_n && lw_n != 16'd0 && ln_n != 16'd0;
    match   = (lw_n == ref_h) && (ln_n == ref_v);
    tmo     = (state != IDLE) &&
              (wd_inc == 24'(TIMEOUT_CYC));
  end

  always_comb begin
    state_n = state;
    stab_n  = stab;
    ref_h_n = ref_h;
    ref_v_n = ref_v;
    fmt_n   = 1'b0;
    ld      = 1'b0;
    if (tmo) begin
      state_n = IDLE;
      stab_n  = 4'd0;
    end else if (vs_rise) begin
      case (state)
        IDLE: state_n = MEASURE;
        MEASURE: begin
          if (good) begin
            ref_h_n = lw_n;
            ref_v_n = ln_n;
            stab_n  = 4'd1;
            if (STABLE_FRAMES == 1) begin
              state_n = LOCKED;
              ld      = 1'b1;
            end else begin
              state_n = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (good && match) begin
            stab_n = stab_inc;
            if (stab_inc == 4'(STABLE_FRAMES)) begin
              state_n = LOCKED;
              ld      = 1'b1;
            end
          end else if (good) begin
            ref_h_n = lw_n;
            ref_v_n = ln_n;
            stab_n  = 4'd1;
          end else begin
            state_n = MEASURE;
          end
        end
        LOCKED: begin
          if (!(good && match)) begin
            state_n = MEASURE;
            stab_n  = 4'd0;
            fmt_n   = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d   <= 1'b0;
      vs_d   <= 1'b0;
      px_cnt <= 16'd0;
      line_w <= 16'd0;
      ln_cnt <= 16'd0;
      bad    <= 1'b0;
      wd     <= 24'd0;
    end else begin
      hs_d <= hs;
      vs_d <= vs;
      if (hs_rise)
        px_cnt <= {15'd0, de};
      else if (de && px_cnt != 16'hFFFF)
        px_cnt <= px_cnt + 16'd1;
      if (vs_rise) begin
        line_w <= 16'd0;
        ln_cnt <= 16'd0;
        bad    <= 1'b0;
      end else begin
        line_w <= lw_n;
        ln_cnt <= ln_n;
        bad    <= bad_n;
      end
      if (state == IDLE || tmo || vs_rise)
        wd <= 24'd0;
      else
        wd <= wd_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      stab       <= 4'd0;
      ref_h      <= 16'd0;
      ref_v      <= 16'd0;
      lock       <= 1'b0;
      fmt_change <= 1'b0;
      timeout    <= 1'b0;
      h_active   <= 16'd0;
      v_active   <= 16'd0;
    end else begin
      state      <= state_n;
      stab       <= stab_n;
      ref_h      <= ref_h_n;
      ref_v      <= ref_v_n;
      lock       <= (state_n == LOCKED);
      fmt_change <= fmt_n;
      timeout    <= tmo;
      if (ld) begin
        h_active <= lw_n;
        v_active <= ln_n;
      end
    end
  end

endmodule

// File: doc/video_fmt_lock.md
VIDEO_FMT_LOCK -- requirements
Module: video_fmt_lock

Interface
REQ-001 SHALL have parameter STABLE_FRAMES, default 3: consecutive matching frames required for lock (legal range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 10000000: maximum clk cycles between vs rising edges before the block declares loss of signal (legal range 1..2^24-1).
REQ-003 SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port hs, input, 1: line sync; a rising edge starts a line.
REQ-006 SHALL have port vs, input, 1: frame sync; a rising edge starts a frame.
REQ-007 SHALL have port de, input, 1: active-pixel qualifier.
REQ-008 SHALL have port lock, output, 1: format is stable and the h_active/v_active outputs are valid.
REQ-009 SHALL have port h_active, output, 16: locked active pixels per line.
REQ-010 SHALL have port v_active, output, 16: locked active lines per frame.
REQ-011 SHALL have port fmt_change, output, 1: one-cycle pulse on loss of lock caused by a format mismatch.
REQ-012 SHALL have port timeout, output, 1: one-cycle pulse on loss of signal.

Function
REQ-013 SHALL register hs and vs once (hs_d, vs_d). hs_rise = hs & ~hs_d. vs_rise = vs & ~vs_d.
REQ-014 SHALL count de-high cycles per line in px_cnt (16 bit, saturating at 0xFFFF).
- On an hs_rise cycle, the line closes with the value counted before that cycle.
- px_cnt reloads to 1 if de=1 on that cycle, else to 0.
REQ-015 On line close with px_cnt>0:
- the first such line of the frame SHALL set line_w;
- each later line SHALL set the frame's bad flag if its px_cnt differs from line_w;
- ln_cnt (16 bit, saturating) SHALL increment.
REQ-016 On a cycle with both hs_rise and vs_rise, SHALL close the line first and include it in the ending frame.
REQ-017 On vs_rise, the frame SHALL close with meas_h=line_w and meas_v=ln_cnt (including the REQ-016 line); line_w, ln_cnt and bad SHALL then clear.
- A frame is good iff bad=0, meas_h>0 and meas_v>0.
REQ-018 SHALL implement states IDLE, MEASURE, VERIFY and LOCKED. All transitions evaluate on vs_rise unless stated otherwise.
REQ-019 IDLE: vs_rise -> MEASURE. The partial frame SHALL be discarded.
REQ-020 MEASURE:
- good frame -> store ref_h/ref_v, set stab=1, go to VERIFY; if STABLE_FRAMES=1, go to LOCKED instead.
- otherwise stay in MEASURE.
REQ-021 VERIFY:
- good frame matching ref -> stab+1; when stab+1 = STABLE_FRAMES, go to LOCKED.
- good frame not matching -> reload ref, stab=1, stay in VERIFY.
- bad frame -> MEASURE.
REQ-022 LOCKED:
- good matching frame -> stay.
- any other frame -> MEASURE, with lock=0 and a fmt_change pulse.
REQ-023 On LOCKED entry, SHALL load h_active=ref_h and v_active=ref_v. lock is registered and SHALL be high from the cycle after the vs_rise that completes lock.
- h_active/v_active SHALL hold their values after lock drops, until the next lock.
REQ-024 SHALL keep a 24-bit watchdog that clears on vs_rise and otherwise increments.
- On reaching TIMEOUT_CYC in any non-IDLE state, SHALL go to IDLE, drop lock, pulse timeout for one cycle and clear stab.
- In IDLE, the watchdog SHALL hold at 0.
REQ-025 A timeout SHALL take priority over a vs_rise in the same cycle. fmt_change and timeout SHALL never pulse in the same cycle.
REQ-026 Both pulses SHALL be registered and SHALL appear the cycle after the triggering edge.

Reset
REQ-027 rst_n low SHALL asynchronously force:
- state=IDLE;
- lock, fmt_change and timeout to 0;
- h_active and v_active to 0;
- all counters, ref, stab, hs_d and vs_d to 0.
REQ-028 Reset mid-lock SHALL lose all history. After release, the first vs_rise goes to IDLE->MEASURE, and lock needs STABLE_FRAMES further good frames.

Verification
REQ-029 Scenario 1: STABLE_FRAMES=3, frames of 4 lines x 8 de cycles.
- lock SHALL rise one cycle after the 4th vs_rise (1 discard, 3 measured).
- h_active=8, v_active=4.
REQ-030 Scenario 2: locked, then one frame with 10 px lines.
- At that frame's closing vs_rise: fmt_change pulses 1 cycle, lock=0, h_active stays 8.
- Relock at 10x4 after 3 more frames.
REQ-031 Scenario 3: one line of 7 px inside an 8 px frame while in VERIFY.
- Return to MEASURE, no lock.
- Lock follows 3 clean frames later.
REQ-032 Scenario 4: locked, TIMEOUT_CYC=1000, vs stopped.
- timeout pulses exactly 1000 cycles after the last vs_rise; lock=0; state=IDLE.
REQ-033 Scenario 5: hs_rise and vs_rise in the same cycle on the last line.
- That line SHALL be counted: v_active=4.
- de high on that cycle counts as pixel 1 of the new line.
REQ-034 Scenario 6: rst_n pulsed low for 1 cycle while locked.
- All outputs are 0 immediately (asynchronously).
- lock reasserts only after 4 vs_rise edges.
